ram32_arbiter: RTL
==================

Name: ram32_arbiter

Overview:
- Two-requester controller for the single-port RAM32 macro (32 words x 32 bits, 4 byte write enables, synchronous read).
- After reset it clears the whole array, then grants round-robin access with a valid/ready handshake per requester.
- It drives the macro's EN0/A0/WE0/Di0 pins and returns Do0 to the granted requester one cycle later.
- Sits between the top-level pin-decode logic and the RAM32 instance.

Parameters:
- INIT_VALUE, 32'h0000_0000, word written to every address during the init sweep
- INIT_ON_RESET, 1, 1 = run the init sweep after reset; 0 = go straight to RUN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A: request present
- a_ready  out  1  requester A: request accepted this cycle
- a_we  in  1  requester A: 1 = write, 0 = read
- a_be  in  4  requester A: byte enables; bit i covers data[8i+7:8i]
- a_addr  in  5  requester A: word address
- a_wdata  in  32  requester A: write data
- a_rsp_valid  out  1  requester A: response strobe
- a_rdata  out  32  requester A: read data
- b_valid, b_ready, b_we, b_be, b_addr, b_wdata, b_rsp_valid, b_rdata: same as the A port, for requester B
- clear  in  1  one-cycle pulse that restarts the init sweep
- init_done  out  1  high in RUN state
- ram_en  out  1  to EN0
- ram_addr  out  5  to A0
- ram_we  out  4  to WE0
- ram_di  out  32  to Di0
- ram_do  in  32  from Do0; valid the cycle after an enabled access

Behaviour:
- Reset values: state = INIT if INIT_ON_RESET, else RUN; init counter = 0; rr pointer = A.
- Reset values continued: a_rsp_valid/b_rsp_valid = 0; a_rdata/b_rdata = 0; ram_en/ram_we = 0; init_done = 0 (1 if INIT_ON_RESET = 0).
- INIT state:
  - Each cycle: ram_en = 1, ram_addr = cnt, ram_we = 4'hF, ram_di = INIT_VALUE.
  - cnt increments 0..31; after the cnt = 31 write, go to RUN.
  - The sweep takes exactly 32 cycles. init_done rises on the cycle after the last write.
  - a_ready and b_ready are held at 0 throughout.
- RUN state, arbitration:
  - Grant is combinational in the same cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the rr pointer is granted, and the pointer moves to the other requester.
  - A single-requester grant also sets the pointer to the other requester.
  - x_ready = grant to x. The transfer happens when x_valid and x_ready are both high.
- RUN state, RAM drive:
  - On a transfer: ram_en = 1 and ram_addr = x_addr.
  - ram_we = x_be when x_we = 1, else 4'h0. ram_di = x_wdata, passed straight through with no byte shifting.
  - With no transfer: ram_en = 0 and ram_we = 0.
- Response:
  - A one-bit owner register plus a pending flag record each transfer.
  - In the next cycle, x_rsp_valid = 1 for exactly one cycle.
  - For reads, x_rdata is registered from ram_do at the end of that response cycle. The data is therefore visible from the cycle after x_rsp_valid onwards and holds until the next read response.
  - Writes also produce x_rsp_valid (as an acknowledge) and leave x_rdata unchanged.
  - Latency from transfer to rsp_valid is 1 cycle. Throughput is one access per cycle, back-to-back across requesters.
- Write with be = 0: ram_en = 1, no bytes change, still acknowledged.
- Read-after-write to the same address in consecutive cycles: returns the new data, provided the macro's write-then-read ordering holds. No forwarding logic inside this block.
- clear in RUN: the next state is INIT with cnt = 0, and no grant is issued in that cycle.
  - The response to the previous cycle's transfer is still delivered.
  - clear during INIT restarts the sweep from cnt = 0.
- Asynchronous reset mid-operation: all state returns to reset values and pending responses are dropped (no rsp_valid is emitted).
- Requesters must hold their request stable while valid is high and ready is low. The arbiter does not check this.

Decomposition:
- Shared package ram32_pkg holds:
  - RAM32_WORDS = 32, RAM32_AW = 5, RAM32_DW = 32, RAM32_BEW = 4
  - the state enum {ST_INIT, ST_RUN}
  - the requester id enum {REQ_A, REQ_B}
- One sub-module, rr_arb2: a two-way round-robin grant with a pointer register.
- The init FSM and the response pipeline stay in ram32_arbiter.

Test Plan:
- Init sweep: INIT_VALUE = 32'hA5A5A5A5, release rst; count ram_we = F cycles.
  - Expect exactly 32, at addresses 0..31, with init_done rising in cycle 33.
  - A read of address 7 then returns A5A5A5A5.
- Contention: A and B both valid with reads of addresses 3 and 4 for 4 cycles.
  - Expect grants A,B,A,B, each rsp_valid one cycle after its grant, and the correct data on each port.
- Byte write: write 32'h11223344 with be = F to address 9, then 32'hFFFFFFFF with be = 4'b0010 to address 9.
  - Expect a read of address 9 to return 32'h1122FF44.
- Single requester streaming: B reads addresses 0..7 every cycle with A idle.
  - Expect b_ready high every cycle and 8 consecutive b_rsp_valid pulses.
- clear mid-traffic: assert clear on a cycle where A is valid.
  - Expect a_ready = 0 that cycle, the previous response still delivered, a 32-cycle sweep, and all words reading INIT_VALUE afterwards.
- Reset mid-operation: assert rst in the cycle after an A read transfer.
  - Expect no a_rsp_valid, all outputs at reset values immediately, and the sweep restarting after rst is released.

Source files
------------

// File: rtl/ram32_pkg.sv
// Shared sizes and enums for the RAM32 arbiter slice.
package ram32_pkg;
    localparam int RAM32_WORDS = 32;
    localparam int RAM32_AW    = 5;
    localparam int RAM32_DW    = 32;
    localparam int RAM32_BEW   = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef enum logic {REQ_A, REQ_B} req_e;
endpackage

// File: rtl/ram32_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer always moves to the requester not just served.
module rr_arb2
    import ram32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);
    req_e r_ptr;

    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        if (i_en) begin
            if (i_req_a && i_req_b) begin
                o_gnt_a = (r_ptr == REQ_A);
                o_gnt_b = (r_ptr == REQ_B);
            end else begin
                o_gnt_a = i_req_a;
                o_gnt_b = i_req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= REQ_A;
        end else if (o_gnt_a) begin
            r_ptr <= REQ_B;
        end else if (o_gnt_b) begin
            r_ptr <= REQ_A;
        end
    end
endmodule

// File: rtl/ram32_arbiter.sv
// Two-requester controller for the RAM32 macro: init sweep after reset/clear,
// then round-robin single-cycle accesses with a one-cycle response strobe.
module ram32_arbiter
    import ram32_pkg::*;
#(
    parameter logic [RAM32_DW-1:0] INIT_VALUE    = 32'h0000_0000,
    parameter bit                  INIT_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_we,
    input  logic [RAM32_BEW-1:0] a_be,
    input  logic [RAM32_AW-1:0]  a_addr,
    input  logic [RAM32_DW-1:0]  a_wdata,
    output logic                 a_rsp_valid,
    output logic [RAM32_DW-1:0]  a_rdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_we,
    input  logic [RAM32_BEW-1:0] b_be,
    input  logic [RAM32_AW-1:0]  b_addr,
    input  logic [RAM32_DW-1:0]  b_wdata,
    output logic                 b_rsp_valid,
    output logic [RAM32_DW-1:0]  b_rdata,
    input  logic                 clear,
    output logic                 init_done,
    output logic                 ram_en,
    output logic [RAM32_AW-1:0]  ram_addr,
    output logic [RAM32_BEW-1:0] ram_we,
    output logic [RAM32_DW-1:0]  ram_di,
    input  logic [RAM32_DW-1:0]  ram_do
);
    state_e                r_state;
    state_e                w_state_nxt;
    logic [RAM32_AW-1:0]   r_cnt;
    logic [RAM32_AW-1:0]   w_cnt_nxt;
    logic                  r_pend;
    logic                  r_pend_rd;
    req_e                  r_owner;
    logic [RAM32_DW-1:0]   r_a_rdata;
    logic [RAM32_DW-1:0]   r_b_rdata;
    logic                  w_arb_en;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_xfer_a;
    logic                  w_xfer_b;

    // The macro pins stay quiet while reset is held, even though the state already reads INIT.
    assign w_arb_en = !rst && (r_state == ST_RUN) && !clear;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_arb_en),
        .i_req_a (a_valid),
        .i_req_b (b_valid),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign a_ready  = w_gnt_a;
    assign b_ready  = w_gnt_b;
    assign w_xfer_a = a_valid && w_gnt_a;
    assign w_xfer_b = b_valid && w_gnt_b;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ram_en      = 1'b0;
        ram_addr    = '0;
        ram_we      = '0;
        ram_di      = '0;
        case (r_state)
            ST_INIT: begin
                if (!rst) begin
                    ram_en   = 1'b1;
                    ram_addr = r_cnt;
                    ram_we   = '1;
                    ram_di   = INIT_VALUE;
                end
                if (r_cnt == RAM32_AW'(RAM32_WORDS - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_xfer_a) begin
                    ram_en   = 1'b1;
                    ram_addr = a_addr;
                    ram_we   = a_we ? a_be : '0;
                    ram_di   = a_wdata;
                end else if (w_xfer_b) begin
                    ram_en   = 1'b1;
                    ram_addr = b_addr;
                    ram_we   = b_we ? b_be : '0;
                    ram_di   = b_wdata;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (clear) begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_pend_rd <= 1'b0;
            r_owner   <= REQ_A;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_pend    <= w_xfer_a || w_xfer_b;
            r_pend_rd <= w_xfer_a ? !a_we : !b_we;
            r_owner   <= w_xfer_b ? REQ_B : REQ_A;
            if (r_pend && r_pend_rd && (r_owner == REQ_A)) begin
                r_a_rdata <= ram_do;
            end
            if (r_pend && r_pend_rd && (r_owner == REQ_B)) begin
                r_b_rdata <= ram_do;
            end
        end
    end

    assign a_rsp_valid = r_pend && (r_owner == REQ_A);
    assign b_rsp_valid = r_pend && (r_owner == REQ_B);
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign init_done   = (r_state == ST_RUN);
endmodule
